// File: rtl/package_settings.sv
// ---------------------------------------------------------------------------
// package_settings
// Project-wide data-path widths shared by the ADC front end and the filters.
// ---------------------------------------------------------------------------
package package_settings;

  // Width of one ADC sample (unsigned).
  localparam int SIZE_ADC_DATA = 14;

endpackage : package_settings

// File: rtl/v1_parameters.sv
// ---------------------------------------------------------------------------
// v1_parameters
// Constants of the variant-1 trapezoidal signal chain. The filter and the
// pulse emulator read the same decay shift, so the emulated exponential tail
// always matches the filter's pole-zero constant.
// ---------------------------------------------------------------------------
package v1_parameters;

  // Pole-zero / tail time constant: tau ~= 2^V1_DECAY_SHIFT clocks.
  localparam int V1_DECAY_SHIFT = 4;

  // Pulse emulator defaults.
  localparam int V1_BASELINE    = 512;   // idle ADC level
  localparam int V1_RISE_SHIFT  = 2;     // leading edge lasts 2^shift samples
  localparam int V1_MAX_LEN     = 1024;  // longest allowed tail, in samples
  localparam int V1_HOLDOFF_LEN = 16;    // baseline gap after each pulse

  // Pulse emulator sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RISE,
    ST_DECAY,
    ST_HOLDOFF
  } emu_state_t;

endpackage : v1_parameters

// File: rtl/v1_pulse_emulator.sv
// ---------------------------------------------------------------------------
// v1_pulse_emulator
// Deterministic detector-pulse source standing in for the ADC in front of
// v1_filter. A start request produces BASELINE + pulse, where the pulse has a
// linear leading edge of 2^RISE_SHIFT samples, an exact peak, and a
// shift-subtract exponential tail, followed by a fixed baseline hold-off.
//
// Ports
//   clk          in   sample clock
//   reset        in   asynchronous, active-low reset
//   start        in   pulse request (accepted only while ready is high)
//   amplitude    in   pulse height above baseline, unsigned
//   ready        out  high only while idle
//   adc_data     out  registered sample, BASELINE + pulse, saturating
//   pulse_active out  high while adc_data carries a rise or tail sample
//   pulse_strobe out  one-cycle marker aligned with the peak sample
//   overrun      out  sticky: start seen while busy; cleared by reset only
// ---------------------------------------------------------------------------
module v1_pulse_emulator
  import v1_parameters::*;
#(
  parameter int SIZE_ADC_DATA = package_settings::SIZE_ADC_DATA,
  parameter int BASELINE      = V1_BASELINE,
  parameter int RISE_SHIFT    = V1_RISE_SHIFT,
  parameter int DECAY_SHIFT   = V1_DECAY_SHIFT,
  parameter int MAX_LEN       = V1_MAX_LEN,
  parameter int HOLDOFF_LEN   = V1_HOLDOFF_LEN
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [SIZE_ADC_DATA-1:0] amplitude,
  output logic                     ready,
  output logic [SIZE_ADC_DATA-1:0] adc_data,
  output logic                     pulse_active,
  output logic                     pulse_strobe,
  output logic                     overrun
);

  localparam int RISE_LEN = 1 << RISE_SHIFT;
  localparam int CNT_TOP  = (MAX_LEN > HOLDOFF_LEN)
                            ? ((MAX_LEN > RISE_LEN) ? MAX_LEN : RISE_LEN)
                            : ((HOLDOFF_LEN > RISE_LEN) ? HOLDOFF_LEN : RISE_LEN);
  localparam int CNT_W    = $clog2(CNT_TOP + 1);

  localparam logic [SIZE_ADC_DATA-1:0] ADC_MAX = '1;
  localparam logic [SIZE_ADC_DATA-1:0] BASE_V  = SIZE_ADC_DATA'(BASELINE);
  // Largest amplitude that still fits above the baseline without clipping.
  localparam logic [SIZE_ADC_DATA-1:0] AMP_MAX =
    SIZE_ADC_DATA'((1 << SIZE_ADC_DATA) - 1 - BASELINE);

  localparam logic [CNT_W-1:0] RISE_LAST  = CNT_W'(RISE_LEN - 1);
  localparam logic [CNT_W-1:0] DECAY_LAST = CNT_W'(MAX_LEN - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLDOFF_LEN - 1);

  emu_state_t               r_state, w_state_nxt;
  logic [SIZE_ADC_DATA-1:0] r_amp, r_step, r_pulse;
  logic [CNT_W-1:0]         r_cnt;
  logic                     r_stage_active, r_stage_peak;
  logic [SIZE_ADC_DATA-1:0] r_adc_data;
  logic                     r_pulse_active, r_pulse_strobe, r_overrun;

  logic [SIZE_ADC_DATA-1:0] w_amp_clamped;
  logic [SIZE_ADC_DATA-1:0] w_shifted, w_dec, w_decayed;
  logic                     w_decay_end;
  logic [SIZE_ADC_DATA:0]   w_sum;
  logic [SIZE_ADC_DATA-1:0] w_adc_nxt;
  logic [SIZE_ADC_DATA-1:0] w_pulse_nxt;
  logic [CNT_W-1:0]         w_cnt_nxt;
  logic                     w_stage_active, w_stage_peak;

  // -------------------------------------------------------------------------
  // Data-path helpers
  // -------------------------------------------------------------------------
  assign w_amp_clamped = (amplitude > AMP_MAX) ? AMP_MAX : amplitude;

  // Tail step: pulse/2^DECAY_SHIFT, but never less than 1 so small pulses
  // still reach zero instead of stalling on the truncated shift.
  assign w_shifted   = r_pulse >> DECAY_SHIFT;
  assign w_dec       = (w_shifted == '0) ? SIZE_ADC_DATA'(1) : w_shifted;
  assign w_decayed   = (r_pulse > w_dec) ? (r_pulse - w_dec) : '0;
  assign w_decay_end = (w_decayed == '0) || (r_cnt == DECAY_LAST);

  assign w_sum     = {1'b0, BASE_V} + {1'b0, r_pulse};
  assign w_adc_nxt = w_sum[SIZE_ADC_DATA] ? ADC_MAX : w_sum[SIZE_ADC_DATA-1:0];

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking (<=) so every register samples the
  // pre-edge values; combinational blocks use blocking (=).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  // NOTE: the default assignment at the top of each always_comb means every
  // path drives every signal, so no latch can be inferred.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:    if (start)                w_state_nxt = ST_RISE;
      ST_RISE:    if (r_cnt == RISE_LAST)   w_state_nxt = ST_DECAY;
      ST_DECAY:   if (w_decay_end)          w_state_nxt = ST_HOLDOFF;
      ST_HOLDOFF: if (r_cnt == HOLD_LAST)   w_state_nxt = ST_IDLE;
      default:                              w_state_nxt = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: output / data-path next values
  // -------------------------------------------------------------------------
  assign ready = (r_state == ST_IDLE);

  always_comb begin
    w_pulse_nxt    = '0;
    w_cnt_nxt      = '0;
    w_stage_active = 1'b0;
    w_stage_peak   = 1'b0;
    unique case (r_state)
      ST_IDLE: ;
      ST_RISE: begin
        w_stage_active = 1'b1;
        if (r_cnt == RISE_LAST) begin
          // Final rise sample lands exactly on amp, hiding step truncation.
          w_pulse_nxt  = r_amp;
          w_stage_peak = 1'b1;
        end else begin
          w_pulse_nxt = r_pulse + r_step;
          w_cnt_nxt   = r_cnt + 1'b1;
        end
      end
      ST_DECAY: begin
        w_stage_active = 1'b1;
        if (!w_decay_end) begin
          w_pulse_nxt = w_decayed;
          w_cnt_nxt   = r_cnt + 1'b1;
        end
      end
      ST_HOLDOFF: begin
        if (r_cnt != HOLD_LAST) w_cnt_nxt = r_cnt + 1'b1;
      end
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Data-path and output registers. The pulse stage and the output stage are
  // one clock apart; the activity/peak flags travel with the pulse value so
  // they stay aligned with adc_data.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_amp          <= '0;
      r_step         <= '0;
      r_pulse        <= '0;
      r_cnt          <= '0;
      r_stage_active <= 1'b0;
      r_stage_peak   <= 1'b0;
      r_adc_data     <= BASE_V;
      r_pulse_active <= 1'b0;
      r_pulse_strobe <= 1'b0;
      r_overrun      <= 1'b0;
    end else begin
      if (ready && start) begin
        r_amp  <= w_amp_clamped;
        r_step <= w_amp_clamped >> RISE_SHIFT;
      end
      r_pulse        <= w_pulse_nxt;
      r_cnt          <= w_cnt_nxt;
      r_stage_active <= w_stage_active;
      r_stage_peak   <= w_stage_peak;
      r_adc_data     <= w_adc_nxt;
      r_pulse_active <= r_stage_active;
      r_pulse_strobe <= r_stage_peak;
      if (start && !ready) r_overrun <= 1'b1;
    end
  end

  assign adc_data     = r_adc_data;
  assign pulse_active = r_pulse_active;
  assign pulse_strobe = r_pulse_strobe;
  assign overrun      = r_overrun;

endmodule : v1_pulse_emulator

// File: tb/tb_v1_pulse_emulator.sv
// ---------------------------------------------------------------------------
// tb_v1_pulse_emulator
// Bench for v1_pulse_emulator. A behavioural model turns each accepted
// amplitude into the full list of pulse values (rise, peak, tail) and tracks
// how many edges have passed since acceptance; a compare process checks
// every output against it on each falling edge. Directed scenarios add
// hand-computed literal expectations. A second instance with MAX_LEN=8
// covers the forced tail cut-off.
// ---------------------------------------------------------------------------
module tb_v1_pulse_emulator;

  localparam int BASE    = 512;
  localparam int R       = 4;
  localparam int DS      = 4;
  localparam int H       = 16;
  localparam int ADC_MAX = 16383;
  localparam int AMP_MAX = ADC_MAX - BASE;

  typedef int iq_t[$];

  logic        clk;
  logic        reset;
  logic        start, start2;
  logic [13:0] amplitude, amplitude2;
  logic        ready, ready2;
  logic [13:0] adc_data, adc_data2;
  logic        pulse_active, pulse_active2;
  logic        pulse_strobe, pulse_strobe2;
  logic        overrun, overrun2;

  int n_tests = 0;
  int n_fail  = 0;

  v1_pulse_emulator dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .amplitude    (amplitude),
    .ready        (ready),
    .adc_data     (adc_data),
    .pulse_active (pulse_active),
    .pulse_strobe (pulse_strobe),
    .overrun      (overrun)
  );

  v1_pulse_emulator #(.MAX_LEN(8)) dut_ml (
    .clk          (clk),
    .reset        (reset),
    .start        (start2),
    .amplitude    (amplitude2),
    .ready        (ready2),
    .adc_data     (adc_data2),
    .pulse_active (pulse_active2),
    .pulse_strobe (pulse_strobe2),
    .overrun      (overrun2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Pulse values the emulator must produce for one request: R rise values
  // (i*step, last one exactly amp) followed by the tail, which ends with a
  // forced 0 once the value hits zero or max_len tail samples are reached.
  function automatic iq_t make_seq(input int amp_in, input int max_len);
    iq_t s;
    int  a, step, p, d;
    a    = (amp_in > AMP_MAX) ? AMP_MAX : amp_in;
    step = a / R;
    for (int i = 1; i < R; i++) s.push_back(i * step);
    s.push_back(a);
    p = a;
    for (int j = 1; j <= max_len; j++) begin
      d = p / (1 << DS);
      if (d < 1) d = 1;
      p = (p > d) ? p - d : 0;
      if (p == 0 || j == max_len) begin
        s.push_back(0);
        break;
      end
      s.push_back(p);
    end
    return s;
  endfunction

  // ---------------------------------------------------------------------
  // Model state: m_n = edges since the last accepted start (-1: none yet).
  // ---------------------------------------------------------------------
  int  m_n = -1;
  iq_t m_seq;
  bit  m_overrun = 1'b0;

  function automatic bit m_idle();
    return (m_n < 0) || (m_n >= m_seq.size() + H);
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        if (start && m_idle()) begin
          m_seq = make_seq(int'(amplitude), 1024);
          m_n   = 0;
        end else begin
          if (start) m_overrun = 1'b1;
          if (m_n >= 0) m_n++;
        end
      end
    end
  end

  // Compare process: every falling edge, all outputs against the model.
  initial begin
    int idx, e_adc;
    bit in_pulse;
    forever begin
      @(negedge clk);
      idx      = m_n - 2;
      in_pulse = (m_n >= 2) && (idx < m_seq.size());
      e_adc    = in_pulse ? BASE + m_seq[idx] : BASE;
      if (e_adc > ADC_MAX) e_adc = ADC_MAX;
      check("adc_data", 32'(adc_data), e_adc);
      check("pulse_active", 32'(pulse_active), 32'(in_pulse));
      check("pulse_strobe", 32'(pulse_strobe), 32'(in_pulse && idx == R - 1));
      check("ready", 32'(ready), 32'(m_idle()));
      check("overrun", 32'(overrun), 32'(m_overrun));
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------
  task automatic pulse_start(input int a);
    @(negedge clk);
    #1 start = 1'b1; amplitude = 14'(a);
    @(negedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int c = 0;
    while (ready !== 1'b1 && c < 2000) begin
      @(negedge clk);
      c++;
    end
    check(name, 32'(ready), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  // Request a pulse and capture adc_data after edges k .. k+n-1.
  task automatic capture_pulse(input int a, input int n, output int cap[32]);
    @(negedge clk);
    #1 start = 1'b1; amplitude = 14'(a);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cap[i] = int'(adc_data);
      if (i == 0) #1 start = 1'b0;
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------------------------------------------------------------
  // Directed scenarios
  // ---------------------------------------------------------------------
  initial begin : stim
    int  cap[32];
    iq_t s;
    int  period, exp_period;
    bit  found;

    reset = 1'b1; start = 1'b0; amplitude = '0; start2 = 1'b0; amplitude2 = '0;
    #3 reset = 1'b0;
    #1;
    check("rst_adc", 32'(adc_data), 512);
    check("rst_ready", 32'(ready), 1);
    check("rst_active", 32'(pulse_active), 0);
    check("rst_strobe", 32'(pulse_strobe), 0);
    check("rst_overrun", 32'(overrun), 0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    repeat (2) @(negedge clk);

    // Pin the model with hand-computed values.
    s = make_seq(1600, 1024);
    check("model_basic_0", BASE + s[0], 912);
    check("model_basic_3", BASE + s[3], 2112);
    check("model_basic_5", BASE + s[5], 1919);
    s = make_seq(5, 1024);
    check("model_small_len", s.size(), 9);
    check("model_small_3", BASE + s[3], 517);
    s = make_seq(16383, 1024);
    check("model_sat_peak", BASE + s[3], 16383);
    s = make_seq(0, 1024);
    check("model_zero_len", s.size(), R + 1);

    // Basic pulse with literal expectations on the DUT.
    capture_pulse(1600, 8, cap);
    check("basic_s0", cap[2], 912);
    check("basic_s1", cap[3], 1312);
    check("basic_s2", cap[4], 1712);
    check("basic_peak", cap[5], 2112);
    check("basic_t0", cap[6], 2012);
    check("basic_t1", cap[7], 1919);
    wait_ready("basic_done");

    // Saturation: clamped amplitude, peak exactly full scale.
    pulse_start(16383);
    wait_ready("sat_done");

    // Small amplitude: rise 513..517, tail ends at baseline.
    capture_pulse(5, 12, cap);
    check("small_r0", cap[2], 513);
    check("small_r3", cap[5], 517);
    check("small_t0", cap[6], 516);
    check("small_t3", cap[9], 513);
    check("small_t4", cap[10], 512);
    wait_ready("small_done");

    // Zero amplitude still runs the whole sequence.
    pulse_start(0);
    wait_ready("zero_done");

    // Busy request mid-tail: ignored, overrun sticks.
    check("overrun_pre", 32'(overrun), 0);
    pulse_start(1600);
    repeat (R + 6) @(negedge clk);
    #1 start = 1'b1; amplitude = 14'd9999;
    @(negedge clk);
    #1 start = 1'b0;
    check("overrun_set", 32'(overrun), 1);
    wait_ready("busy_done");
    pulse_start(300);
    wait_ready("after_busy_done");
    check("overrun_sticky", 32'(overrun), 1);

    // Back-to-back with start held high.
    s          = make_seq(100, 1024);
    exp_period = s.size() + H + 1;
    @(negedge clk);
    #1 start = 1'b1; amplitude = 14'd100;
    found  = 1'b0;
    period = 0;
    for (int c = 1; c < 400; c++) begin
      @(negedge clk);
      if (ready === 1'b1) begin
        period = c;
        found  = 1'b1;
        break;
      end
    end
    check("b2b_found", 32'(found), 1);
    check("b2b_period", period, exp_period);
    @(negedge clk);
    #1 start = 1'b0;
    wait_ready("b2b_done");

    // Reset during the rise: immediate return to idle values.
    pulse_start(1600);
    @(negedge clk);
    #2 reset = 1'b0;
    m_n = -1; m_overrun = 1'b0;
    #1;
    check("midrst_adc", 32'(adc_data), 512);
    check("midrst_ready", 32'(ready), 1);
    check("midrst_active", 32'(pulse_active), 0);
    check("midrst_overrun", 32'(overrun), 0);
    @(negedge clk);
    #2 reset = 1'b1;
    pulse_start(1600);
    wait_ready("after_rst_done");

    // MAX_LEN=8 instance: tail cut after 8 samples, drop straight to 512.
    @(negedge clk);
    #1 start2 = 1'b1; amplitude2 = 14'd1600;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      cap[i] = int'(adc_data2);
      if (i == 13) check("ml_active_last", 32'(pulse_active2), 1);
      if (i == 14) check("ml_active_after", 32'(pulse_active2), 0);
      if (i == 0) #1 start2 = 1'b0;
    end
    check("ml_peak", cap[5], 2112);
    check("ml_t0", cap[6], 2012);
    check("ml_t2", cap[8], 1832);
    check("ml_t5", cap[11], 1601);
    check("ml_t6", cap[12], 1533);
    check("ml_cut", cap[13], 512);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_v1_pulse_emulator

// File: doc/v1_pulse_emulator.md
# v1_pulse_emulator

Synthetic detector-pulse source that drives the ADC-side input of the variant-1 trapezoidal filter with deterministic, bit-exact samples. On a `start` request it emits a baseline-offset pulse with a linear leading edge and an exponential tail. The tail is built with a shift-subtract recursion whose decay matches the filter's pole-zero constant. The block sits in front of `v1_filter` in bench and self-test builds, replacing the physical ADC.

## Interface
Parameters:
- `SIZE_ADC_DATA`, 14, sample width (from `package_settings`)
- `BASELINE`, 512, idle output level (unsigned)
- `RISE_SHIFT`, 2, leading edge lasts R = 2^RISE_SHIFT samples
- `DECAY_SHIFT`, 4, tail time constant ≈ 2^DECAY_SHIFT clocks
- `MAX_LEN`, 1024, maximum number of DECAY cycles before forced end
- `HOLDOFF_LEN`, 16, idle gap after each pulse

Ports:
- `clk`  in  1  sample clock
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  pulse request, sampled on rising `clk`
- `amplitude`  in  SIZE_ADC_DATA  pulse height above baseline, unsigned
- `ready`  out  1  high only in IDLE; `start` is accepted only when high
- `adc_data`  out  SIZE_ADC_DATA  registered sample = BASELINE + pulse
- `pulse_active`  out  1  high while `adc_data` carries a RISE or DECAY sample
- `pulse_strobe`  out  1  one-cycle pulse aligned with the peak sample on `adc_data`
- `overrun`  out  1  sticky; set when `start` arrives while `ready`=0, cleared only by reset

## Operation
- FSM states: IDLE, RISE, DECAY, HOLDOFF. Internal `pulse` register is unsigned, SIZE_ADC_DATA bits.
- **IDLE**
  - `pulse`=0.
  - `start`=1 latches `amp` = min(`amplitude`, 2^SIZE_ADC_DATA-1-BASELINE).
  - Sets `step` = `amp`>>RISE_SHIFT, clears `cnt`, moves to RISE.
- **RISE**
  - Each cycle `pulse` += `step` and `cnt`++.
  - On the R-th cycle `pulse` is loaded with exactly `amp`, absorbing the truncation error; the state then moves to DECAY.
- **DECAY**
  - Each cycle `pulse` -= max(1, `pulse`>>DECAY_SHIFT).
  - When `pulse` reaches 0, or the DECAY cycle count reaches MAX_LEN, `pulse` is forced to 0 and the state moves to HOLDOFF.
- **HOLDOFF**
  - Lasts HOLDOFF_LEN cycles with `pulse`=0, then returns to IDLE.
- `start` in any state other than IDLE is ignored (no queueing) and sets `overrun`.
- `adc_data` <= BASELINE + `pulse`, saturating at 2^SIZE_ADC_DATA-1. The clamp on `amp` means this saturation is never reached in practice.
- `amp`=0 still runs the full sequence: flat baseline for R samples, one DECAY cycle, then HOLDOFF.

## Timing
- Reset values: `adc_data`=BASELINE, `ready`=1, `pulse_active`=0, `pulse_strobe`=0, `overrun`=0, FSM in IDLE.
- Reset applies immediately, without a clock edge, from any state, including mid-pulse.
- `start` accepted at edge k:
  - `ready` is low after edge k.
  - The first rise sample appears on `adc_data` after edge k+2.
  - The peak appears after edge k+R+1, with `pulse_strobe` high for that cycle only.
- `pulse_active` is pipelined identically to `adc_data`.
- `ready` returns high HOLDOFF_LEN cycles after the DECAY-to-HOLDOFF transition.
- With `start` held high continuously, back-to-back pulses start exactly R + D + HOLDOFF_LEN + 1 cycles apart, where D is the DECAY length. `overrun` sets during the first pulse.
- Throughput is one sample per clock; there are no stalls.

## Structure
- Add BASELINE, RISE_SHIFT, DECAY_SHIFT, MAX_LEN and HOLDOFF_LEN defaults to `v1_parameters`, next to the filter's constants, so the filter and emulator share the decay shift.
- Add the FSM state enum typedef to `v1_parameters`.
- `SIZE_ADC_DATA` comes from `package_settings`.
- Single module; no sub-module is warranted.

## Test plan
All scenarios use default parameters unless stated (BASELINE=512, R=4, DECAY_SHIFT=4).
- **Basic pulse:** `amplitude`=1600.
  - `adc_data` = 912, 1312, 1712, 2112 (strobe), then 2012, 1919.
  - Samples then decay monotonically back to 512, followed by 16 baseline cycles with `ready`=0.
- **Saturation:** `amplitude`=16383 → peak `adc_data`=16383 with no wrap; every tail sample is ≤16383.
- **Small-amplitude termination:** `amplitude`=5.
  - Rise samples are 513, 514, 515, 517.
  - Tail samples are 516, 515, 514, 513, 512, then HOLDOFF.
- **Busy request:** pulse `start` mid-DECAY → ignored and `overrun`=1; the next accepted pulse is unaffected. Only reset clears `overrun`.
- **Reset mid-pulse:** assert `reset` low during RISE → `adc_data`=512 and `ready`=1 immediately. After release, the next `start` produces a correct pulse.
- **MAX_LEN bound:** with MAX_LEN=8, `amplitude`=1600 → DECAY is cut after 8 cycles and `adc_data` drops to 512 in one step.
